// File: rtl/branch_predict_update.sv
// Fetch-side branch predictor: a direct-mapped BTB with 2-bit saturating
// direction counters. It returns a registered prediction one cycle after each
// accepted fetch PC, trains the table from execute-stage resolutions, and
// raises a one-cycle registered redirect when a resolved branch disagrees with
// the prediction that travelled down the pipe with it.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   fetch_pc, fetch_stall    lookup request; stall holds the pred_* outputs
//   pred_valid/taken/target  registered prediction for the last accepted PC
//   resolved_branch          {valid, taken, target} from execute
//   resolved_pc              PC of the resolved branch
//   resolved_pred_taken      direction predicted for that branch at fetch
//   resolved_pred_target     target predicted for that branch at fetch
//   redirect, redirect_pc    one-cycle flush request and restart address
//   mispredict_count         wrapping count of mispredicted resolutions

package branch_predict_pkg;
  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [31:0] target;
  } branch_resolved_t;
endpackage

module branch_predict_update
  import branch_predict_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      fetch_pc,
  input  logic             fetch_stall,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  branch_resolved_t resolved_branch,
  input  logic [31:0]      resolved_pc,
  input  logic             resolved_pred_taken,
  input  logic [31:0]      resolved_pred_target,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      mispredict_count
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  logic [ENTRIES-1:0]            valid_q;
  logic [ENTRIES-1:0][1:0]       ctr_q;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
  logic [ENTRIES-1:0][31:0]      target_q;

  logic             vld_p1;
  logic             pred_taken_p1;
  logic [31:0]      pred_target_p1;
  logic             redirect_p1;
  logic [31:0]      redirect_pc_p1;
  logic [31:0]      mis_count_p1;

  // ---- Stage 0: table update from the resolution ----
  logic [IDX-1:0]   upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             wr_en;
  logic             new_valid;
  logic [TAG_W-1:0] new_tag;
  logic [31:0]      new_target;
  logic [1:0]       new_ctr;

  assign upd_idx = resolved_pc[IDX+1:2];
  assign upd_tag = resolved_pc[31:IDX+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    wr_en      = 1'b0;
    new_valid  = valid_q[upd_idx];
    new_tag    = tag_q[upd_idx];
    new_target = target_q[upd_idx];
    new_ctr    = ctr_q[upd_idx];
    if (resolved_branch.valid) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (resolved_branch.taken) begin
          new_ctr    = ctr_inc(ctr_q[upd_idx]);
          new_target = resolved_branch.target;
        end else begin
          new_ctr = ctr_dec(ctr_q[upd_idx]);
        end
      end else if (resolved_branch.taken) begin
        // Allocation evicts whatever aliased into this slot.
        wr_en      = 1'b1;
        new_valid  = 1'b1;
        new_tag    = upd_tag;
        new_target = resolved_branch.target;
        new_ctr    = 2'b10;
      end
    end
  end

  logic        mis;
  logic [31:0] restart_pc;

  assign mis = resolved_branch.valid &&
               ((resolved_branch.taken != resolved_pred_taken) ||
                (resolved_branch.taken && (resolved_branch.target != resolved_pred_target)));
  assign restart_pc = resolved_branch.taken ? resolved_branch.target : resolved_pc + 32'd8;

  // ---- Stage 0: lookup, bypassing a same-cycle write to the same slot ----
  logic [IDX-1:0]   lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_bypass;
  logic             lk_valid;
  logic [TAG_W-1:0] lk_entry_tag;
  logic [31:0]      lk_entry_target;
  logic [1:0]       lk_ctr;
  logic             lk_taken;
  logic [31:0]      lk_target;

  assign lk_idx          = fetch_pc[IDX+1:2];
  assign lk_tag          = fetch_pc[31:IDX+2];
  assign lk_bypass       = wr_en && (upd_idx == lk_idx);
  assign lk_valid        = lk_bypass ? new_valid  : valid_q[lk_idx];
  assign lk_entry_tag    = lk_bypass ? new_tag    : tag_q[lk_idx];
  assign lk_entry_target = lk_bypass ? new_target : target_q[lk_idx];
  assign lk_ctr          = lk_bypass ? new_ctr    : ctr_q[lk_idx];
  assign lk_taken        = lk_valid && (lk_entry_tag == lk_tag) && lk_ctr[1];
  assign lk_target       = lk_taken ? lk_entry_target : fetch_pc + 32'd8;

  // ---- Stage 1: registered control state and outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= '0;
      ctr_q          <= {ENTRIES{2'b01}};
      vld_p1         <= 1'b0;
      pred_taken_p1  <= 1'b0;
      pred_target_p1 <= '0;
      redirect_p1    <= 1'b0;
      redirect_pc_p1 <= '0;
      mis_count_p1   <= '0;
    end else begin
      if (wr_en) begin
        valid_q[upd_idx] <= new_valid;
        ctr_q[upd_idx]   <= new_ctr;
      end
      if (!fetch_stall) begin
        vld_p1         <= 1'b1;
        pred_taken_p1  <= lk_taken;
        pred_target_p1 <= lk_target;
      end
      redirect_p1 <= mis;
      if (mis) redirect_pc_p1 <= restart_pc;
      mis_count_p1 <= mis_count_p1 + {31'd0, mis};
    end
  end

  // Tag/target storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[upd_idx]    <= new_tag;
      target_q[upd_idx] <= new_target;
    end
  end

  assign pred_valid       = vld_p1;
  assign pred_taken       = pred_taken_p1;
  assign pred_target      = pred_target_p1;
  assign redirect         = redirect_p1;
  assign redirect_pc      = redirect_pc_p1;
  assign mispredict_count = mis_count_p1;

endmodule

// File: doc/branch_predict_update.md
# branch_predict_update

Fetch-side counterpart to the execute-stage branch resolver. It holds a direct-mapped branch target buffer with 2-bit saturating direction counters, supplies a one-cycle-latency prediction for each fetch PC, and consumes `branch_resolved_t` results coming back from execute. From those results it trains the tables and issues a registered redirect when the prediction carried down the pipe was wrong.

## Interface
- `ENTRIES`, 64: BTB entries; must be a power of two, at least 2. `IDX = $clog2(ENTRIES)`.
- `clk  in  1`: clock.
- `rst  in  1`: reset, synchronous, active-high.
- `fetch_pc  in  32`: PC presented by fetch.
- `fetch_stall  in  1`: fetch stalled; hold the prediction outputs.
- `pred_valid  out  1`: prediction outputs correspond to the previous accepted `fetch_pc`.
- `pred_taken  out  1`: predicted taken.
- `pred_target  out  32`: predicted next PC.
- `resolved_branch  in  branch_resolved_t`: fields `valid`, `taken`, `target` from execute.
- `resolved_pc  in  32`: PC of the resolved branch.
- `resolved_pred_taken  in  1`: prediction that travelled with this branch.
- `resolved_pred_target  in  32`: predicted target that travelled with this branch.
- `redirect  out  1`: mispredict; fetch must flush and restart.
- `redirect_pc  out  32`: restart address.
- `mispredict_count  out  32`: performance counter.

## Operation
- Entry contents: `valid`, `tag = pc[31:IDX+2]`, `target[31:0]`, `ctr[1:0]`.
- Index is `pc[IDX+1:2]`. The table is flop-based and is written at the clock edge.

**Lookup**
- When `!fetch_stall`, register the lookup result for `fetch_pc`.
- Hit means `valid && tag match`.
- `pred_taken = hit & ctr[1]`.
- `pred_target`: the entry target when `pred_taken`, otherwise `fetch_pc + 8` (fall-through past the delay slot, 32-bit wrap).
- When `fetch_stall=1`, all `pred_*` outputs hold their values.

**Update** (when `resolved_branch.valid`)
- Hit, taken: `ctr` saturating +1 (max 11); `target ← resolved_branch.target`.
- Hit, not taken: `ctr` saturating −1 (min 00); target unchanged.
- Miss, taken: allocate/overwrite the entry with `valid=1`, new tag, target, `ctr=10`.
- Miss, not taken: no write.

**Mispredict detection**
- `mis = valid & ((taken != resolved_pred_taken) | (taken & target != resolved_pred_target))`.
- `redirect_pc`: `resolved_branch.target` if taken, otherwise `resolved_pc + 8`.
- `mispredict_count` increments by 1 per `mis` and wraps from `0xFFFFFFFF` to 0.

**Simultaneous lookup and update on the same index**
- The lookup sees the post-update entry (write-first bypass), including a newly allocated tag, target and counter.

**Reset**
- Clears every `valid` bit. `ctr` is set to 01 (weakly not-taken). Target and tag contents are don't-care.

## Timing
- Lookup latency is 1 cycle: `fetch_pc` sampled at edge N gives `pred_*` valid after edge N, with `pred_valid=1` from then on.
- `pred_valid` falls to 0 only through reset.
- Update latency: a resolution sampled at edge N writes the table at edge N. `redirect` and `redirect_pc` are registered and visible after edge N for exactly one cycle, unless the next resolution also mispredicts.
- With back-to-back resolutions, each is processed independently in order. The counter update uses the entry state left by the previous cycle's write.
- Reset values:
  - `pred_valid=0`, `pred_taken=0`, `pred_target=0`
  - `redirect=0`, `redirect_pc=0`
  - `mispredict_count=0`
- Reset mid-operation: table valid bits, outputs and counter all clear at the reset edge. A resolution or lookup present in that same cycle is discarded.
- There is no backpressure on the resolution side; every valid result is consumed in its cycle.

## Test plan
- **Cold lookup after reset:** `fetch_pc=0x80000100` → next cycle `pred_valid=1`, `pred_taken=0`, `pred_target=0x80000108`.
- **Taken branch on a miss:** resolve `pc=0x80000100`, taken, `target=0x80000200`, `pred_taken=0`.
  - Required: `redirect=1`, `redirect_pc=0x80000200`, `mispredict_count=1`.
  - A following lookup of `0x80000100` predicts taken to `0x80000200` (`ctr=10`).
- **Counter saturation:** three taken resolutions take `ctr` to 11.
  - One not-taken resolution then gives `ctr=10`; the entry still predicts taken.
  - A second not-taken resolution gives `ctr=01`; the entry predicts not-taken to `pc+8`, and that resolution reports `redirect_pc = pc+8`.
- **Correct prediction:** taken, `target=0x80000200`, `pred_taken=1`, `pred_target=0x80000200` → `redirect=0` and the counter is unchanged.
- **Same-cycle collision:**
  - Setup: `ENTRIES=64`; `0x80000100` is allocated as a taken branch.
  - Stimulus: resolve `0x80001100` (same index, different tag) taken to `0x80003000` in the same cycle as a lookup of `0x80001100`.
  - Required: the lookup predicts taken to `0x80003000`.
  - Required: a later lookup of `0x80000100` misses.
- **Stall and reset:**
  - With `fetch_stall=1` and `fetch_pc` changing, `pred_*` hold.
  - Asserting `rst` with a pending mispredict gives `redirect=0` and `mispredict_count=0`.
  - After reset, every previously trained PC misses.
